// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the conv_nn frame admission scheduler.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } sched_state_t;

    localparam int INFLIGHT_W = 4;

    // Bits needed to count 0..timeout_cyc-1, never narrower than one bit.
    function automatic int wd_width(input int timeout_cyc);
        int w;
        w = $clog2(timeout_cyc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/conv_sched_watchdog.sv
// Idle watchdog for conv_nn output: counts cycles while run=1 and kick=0,
// expire is high for the single cycle in which the count reaches TIMEOUT_CYC-1.
module conv_sched_watchdog
    import conv_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int               CNT_W    = wd_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_r;

    // Combinational so the owner can clear its state on the same edge it flags the timeout.
    assign expire = run && !kick && (cnt_r == CNT_LAST);

    // Idle counter: restarts on pipe activity, when nothing is in flight, and after expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (!run || kick || expire) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/conv_frame_scheduler.sv
// Frame admission controller in front of conv_nn with in-flight tracking and watchdog flush.
// Optional statistics counters are built when CONV_SCHED_STATS_EN is defined.
module conv_frame_scheduler
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_INFLIGHT = 2,
    parameter int TIMEOUT_CYC  = 2**20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o,
    input  logic                  pipe_valid_i,
    input  logic                  pipe_eof_i,
    output logic [INFLIGHT_W-1:0] inflight_o,
    output logic                  busy_o,
    output logic                  drop_o,
    output logic                  timeout_o,
    output logic                  flush_o,
    output logic                  proto_err_o
`ifdef CONV_SCHED_STATS_EN
    ,
    output logic [31:0]           frames_in_o,
    output logic [31:0]           frames_out_o,
    output logic [31:0]           frames_drop_o
`endif
);

    localparam logic [INFLIGHT_W-1:0] MAX_IF = INFLIGHT_W'(MAX_INFLIGHT);

    sched_state_t          state_r;
    sched_state_t          state_next_s;
    logic                  admit_s;
    logic                  fwd_s;
    logic                  drop_s;
    logic                  frame_err_s;
    logic                  pipe_eof_s;
    logic                  underflow_s;
    logic                  expire_s;
    logic                  wd_run_s;
    logic                  proto_err_r;
    logic [INFLIGHT_W-1:0] inflight_r;
    logic [INFLIGHT_W-1:0] inflight_next_s;

    assign inflight_o  = inflight_r;
    assign proto_err_o = proto_err_r;
    assign wd_run_s    = (inflight_r != '0);
    assign pipe_eof_s  = pipe_valid_i && pipe_eof_i;
    assign underflow_s = pipe_eof_s && (inflight_r == '0);

    // Per-beat admission decision and next FSM state.
    always_comb begin
        admit_s      = 1'b0;
        fwd_s        = 1'b0;
        drop_s       = 1'b0;
        frame_err_s  = 1'b0;
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (data_valid_i && sof_i) begin
                    if (enable_i && (inflight_r < MAX_IF)) begin
                        admit_s      = 1'b1;
                        fwd_s        = 1'b1;
                        state_next_s = eof_i ? S_IDLE : S_PASS;
                    end else begin
                        drop_s       = 1'b1;
                        state_next_s = eof_i ? S_IDLE : S_DROP;
                    end
                end else if (data_valid_i) begin
                    frame_err_s = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PASS: begin
                if (data_valid_i) begin
                    fwd_s        = 1'b1;
                    frame_err_s  = sof_i;
                    state_next_s = eof_i ? S_IDLE : S_PASS;
                end else begin
                    state_next_s = S_PASS;
                end
            end
            S_DROP: begin
                if (data_valid_i) begin
                    frame_err_s  = sof_i;
                    state_next_s = eof_i ? S_IDLE : S_DROP;
                end else begin
                    state_next_s = S_DROP;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // In-flight count: a flush wipes older frames but keeps a frame admitted on the same edge.
    always_comb begin
        inflight_next_s = inflight_r;
        if (expire_s) begin
            inflight_next_s = admit_s ? INFLIGHT_W'(1) : '0;
        end else if (admit_s && !pipe_eof_s) begin
            inflight_next_s = (inflight_r < MAX_IF) ? inflight_r + INFLIGHT_W'(1) : inflight_r;
        end else if (pipe_eof_s && !admit_s) begin
            inflight_next_s = underflow_s ? inflight_r : inflight_r - INFLIGHT_W'(1);
        end else begin
            inflight_next_s = inflight_r;
        end
    end

    // FSM state plus the registered conv_nn-facing stream and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            drop_o       <= 1'b0;
            busy_o       <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            data_o       <= fwd_s ? data_i : data_o;
            data_valid_o <= fwd_s;
            sop_o        <= fwd_s && sop_i;
            eop_o        <= fwd_s && eop_i;
            sof_o        <= fwd_s && sof_i;
            eof_o        <= fwd_s && eof_i;
            drop_o       <= drop_s;
            busy_o       <= (state_next_s != S_IDLE) || (inflight_next_s != '0);
            proto_err_r  <= proto_err_r || frame_err_s || underflow_s;
        end
    end

    // In-flight counter and watchdog pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r <= '0;
            timeout_o  <= 1'b0;
            flush_o    <= 1'b0;
        end else begin
            inflight_r <= inflight_next_s;
            timeout_o  <= expire_s;
            flush_o    <= expire_s;
        end
    end

    conv_sched_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (wd_run_s),
        .kick   (pipe_valid_i),
        .expire (expire_s)
    );

`ifdef CONV_SCHED_STATS_EN
    // Free-running wrap-around frame statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_in_o   <= 32'd0;
            frames_out_o  <= 32'd0;
            frames_drop_o <= 32'd0;
        end else begin
            frames_in_o   <= admit_s    ? frames_in_o + 32'd1   : frames_in_o;
            frames_out_o  <= pipe_eof_s ? frames_out_o + 32'd1  : frames_out_o;
            frames_drop_o <= drop_s     ? frames_drop_o + 32'd1 : frames_drop_o;
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed self-checking bench for conv_frame_scheduler (MAX_INFLIGHT=2, TIMEOUT_CYC=16).
module tb_conv_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic       sop_i = 1'b0;
    logic       eop_i = 1'b0;
    logic       sof_i = 1'b0;
    logic       eof_i = 1'b0;
    logic       pipe_valid_i = 1'b0;
    logic       pipe_eof_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       sop_o;
    logic       eop_o;
    logic       sof_o;
    logic       eof_o;
    logic [3:0] inflight_o;
    logic       busy_o;
    logic       drop_o;
    logic       timeout_o;
    logic       flush_o;
    logic       proto_err_o;
`ifdef CONV_SCHED_STATS_EN
    logic [31:0] frames_in_o;
    logic [31:0] frames_out_o;
    logic [31:0] frames_drop_o;
`endif

    int checks   = 0;
    int failures = 0;

    conv_frame_scheduler #(
        .DATA_WIDTH   (8),
        .MAX_INFLIGHT (2),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .sop_i        (sop_i),
        .eop_i        (eop_i),
        .sof_i        (sof_i),
        .eof_i        (eof_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .sop_o        (sop_o),
        .eop_o        (eop_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .pipe_valid_i (pipe_valid_i),
        .pipe_eof_i   (pipe_eof_i),
        .inflight_o   (inflight_o),
        .busy_o       (busy_o),
        .drop_o       (drop_o),
        .timeout_o    (timeout_o),
        .flush_o      (flush_o),
        .proto_err_o  (proto_err_o)
`ifdef CONV_SCHED_STATS_EN
        ,
        .frames_in_o   (frames_in_o),
        .frames_out_o  (frames_out_o),
        .frames_drop_o (frames_drop_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beat();
        data_valid_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
        sof_i = 1'b0;
        eof_i = 1'b0;
    endtask

    task automatic set_beat(input logic [7:0] d, input logic sp, input logic ep,
                            input logic sf, input logic ef);
        data_i = d;
        data_valid_i = 1'b1;
        sop_i = sp;
        eop_i = ep;
        sof_i = sf;
        eof_i = ef;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_beat();
        pipe_valid_i = 1'b0;
        pipe_eof_i = 1'b0;
        enable_i = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Sends one 4x4 frame back-to-back and checks each beat one cycle later.
    task automatic send_frame(input logic [7:0] base, input bit fwd, input bit drop,
                              input bit en_off_mid, input string name);
        logic [7:0] d;
        logic [3:0] fl;
        for (int i = 0; i < 16; i++) begin
            d  = base + 8'(i);
            fl = {(i % 4 == 0), (i % 4 == 3), (i == 0), (i == 15)};
            set_beat(d, fl[3], fl[2], fl[1], fl[0]);
            tick();
            if (en_off_mid && i == 0) enable_i = 1'b0;
            checks++;
            if (data_valid_o !== fwd) begin
                failures++;
                $display("FAIL %s beat %0d valid: got %b want %b", name, i, data_valid_o, fwd);
            end
            checks++;
            if (fwd) begin
                if ({data_o, sop_o, eop_o, sof_o, eof_o} !== {d, fl}) begin
                    failures++;
                    $display("FAIL %s beat %0d data/flags: got %h/%b want %h/%b", name, i,
                             data_o, {sop_o, eop_o, sof_o, eof_o}, d, fl);
                end
            end else begin
                if ({sop_o, eop_o, sof_o, eof_o} !== 4'b0000) begin
                    failures++;
                    $display("FAIL %s beat %0d flags: got %b want 0000", name, i,
                             {sop_o, eop_o, sof_o, eof_o});
                end
            end
            checks++;
            if (drop_o !== (drop && i == 0)) begin
                failures++;
                $display("FAIL %s beat %0d drop_o: got %b want %b", name, i, drop_o, (drop && i == 0));
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, inflight_o, busy_o,
             drop_o, timeout_o, flush_o, proto_err_o} !== 22'd0) begin
            failures++;
            $display("FAIL %s outputs: data=%h v=%b infl=%0d busy=%b drop=%b to=%b fl=%b err=%b want all 0",
                     name, data_o, data_valid_o, inflight_o, busy_o, drop_o, timeout_o, flush_o, proto_err_o);
        end
    endtask

    task automatic check_infl(input logic [3:0] exp, input string name);
        checks++;
        if (inflight_o !== exp) begin
            failures++;
            $display("FAIL %s inflight_o: got %0d want %0d", name, inflight_o, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset");
    endtask

    task automatic test_back_to_back();
        do_reset();
        pipe_valid_i = 1'b1;  // pipe active but no eof keeps the watchdog quiet
        send_frame(8'h10, 1'b1, 1'b0, 1'b0, "bb_f1");
        check_infl(4'd1, "bb_after_f1");
        send_frame(8'h40, 1'b1, 1'b0, 1'b0, "bb_f2");
        check_infl(4'd2, "bb_after_f2");
        send_frame(8'h80, 1'b0, 1'b1, 1'b0, "bb_f3");
        check_infl(4'd2, "bb_after_f3");
        checks++;
        if (data_o !== 8'h4F || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL bb_hold data_o/busy_o: got %h/%b want 4f/1", data_o, busy_o);
        end
        clear_beat();
        pipe_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_eof_with_sof();
        do_reset();
        set_beat(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_infl(4'd1, "eofsof_first");
        set_beat(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
        pipe_valid_i = 1'b1;
        pipe_eof_i = 1'b1;
        tick();
        check_infl(4'd1, "eofsof_same_cycle");
        checks++;
        if ({data_valid_o, data_o, sof_o, eof_o} !== {1'b1, 8'h5A, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL eofsof_fwd: got v=%b d=%h sof=%b eof=%b want 1/5a/1/1",
                     data_valid_o, data_o, sof_o, eof_o);
        end
        clear_beat();
        tick();
        check_infl(4'd0, "eofsof_next_eof");
        pipe_valid_i = 1'b0;
        pipe_eof_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, proto_err_o} !== 2'b00) begin
            failures++;
            $display("FAIL eofsof_idle busy/err: got %b%b want 00", busy_o, proto_err_o);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        set_beat(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        clear_beat();
        check_infl(4'd1, "wd_admit");
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (timeout_o !== 1'b0) begin
                failures++;
                $display("FAIL wd_early cycle %0d timeout_o: got %b want 0", i, timeout_o);
            end
        end
        tick();
        checks++;
        if ({timeout_o, flush_o, inflight_o} !== {1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL wd_expire: got to=%b fl=%b infl=%0d want 1/1/0", timeout_o, flush_o, inflight_o);
        end
        tick();
        checks++;
        if ({timeout_o, flush_o} !== 2'b00) begin
            failures++;
            $display("FAIL wd_pulse_len: got to=%b fl=%b want 0/0", timeout_o, flush_o);
        end
        // Periodic pipe activity must hold off expiry.
        set_beat(8'hC4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        clear_beat();
        for (int i = 1; i <= 40; i++) begin
            pipe_valid_i = (i % 10 == 0);
            tick();
            checks++;
            if (timeout_o !== 1'b0) begin
                failures++;
                $display("FAIL wd_kicked cycle %0d timeout_o: got %b want 0", i, timeout_o);
            end
        end
        pipe_valid_i = 1'b0;
        check_infl(4'd1, "wd_kicked_infl");
        for (int i = 1; i <= 15; i++) tick();
        // Admitted sof on the expiry edge survives the flush.
        set_beat(8'hC5, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        clear_beat();
        checks++;
        if ({timeout_o, data_valid_o, inflight_o} !== {1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL wd_flush_admit: got to=%b v=%b infl=%0d want 1/1/1",
                     timeout_o, data_valid_o, inflight_o);
        end
    endtask

    task automatic test_enable();
        do_reset();
        pipe_valid_i = 1'b1;
        enable_i = 1'b0;
        send_frame(8'h20, 1'b0, 1'b1, 1'b0, "en_off");
        enable_i = 1'b1;
        send_frame(8'h30, 1'b1, 1'b0, 1'b1, "en_mid");
        check_infl(4'd1, "en_mid_infl");
        send_frame(8'h50, 1'b0, 1'b1, 1'b0, "en_after");
        clear_beat();
        pipe_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_proto();
        do_reset();
        set_beat(8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        clear_beat();
        checks++;
        if ({proto_err_o, data_valid_o, inflight_o} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL proto_stray_eof: got err=%b v=%b infl=%0d want 1/0/0",
                     proto_err_o, data_valid_o, inflight_o);
        end
        tick();
        checks++;
        if (proto_err_o !== 1'b1) begin
            failures++;
            $display("FAIL proto_sticky: got %b want 1", proto_err_o);
        end
        do_reset();
        check_all_zero("proto_reset1");
        set_beat(8'h21, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (proto_err_o !== 1'b0) begin
            failures++;
            $display("FAIL proto_first_sof err: got %b want 0", proto_err_o);
        end
        set_beat(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({proto_err_o, data_valid_o, sof_o, inflight_o} !== {1'b1, 1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL proto_double_sof: got err=%b v=%b sof=%b infl=%0d want 1/1/1/1",
                     proto_err_o, data_valid_o, sof_o, inflight_o);
        end
        set_beat(8'h23, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        clear_beat();
        do_reset();
        pipe_valid_i = 1'b1;
        pipe_eof_i = 1'b1;
        tick();
        pipe_valid_i = 1'b0;
        pipe_eof_i = 1'b0;
        checks++;
        if ({proto_err_o, inflight_o} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL proto_underflow: got err=%b infl=%0d want 1/0", proto_err_o, inflight_o);
        end
        tick();
        check_infl(4'd0, "proto_underflow_hold");
        do_reset();
        check_all_zero("proto_reset2");
    endtask

`ifdef CONV_SCHED_STATS_EN
    task automatic test_stats();
        test_back_to_back();
        pipe_valid_i = 1'b1;
        pipe_eof_i = 1'b1;
        tick();
        tick();
        pipe_valid_i = 1'b0;
        pipe_eof_i = 1'b0;
        checks++;
        if ({frames_in_o, frames_drop_o, frames_out_o} !== {32'd2, 32'd1, 32'd2}) begin
            failures++;
            $display("FAIL stats: got in=%0d drop=%0d out=%0d want 2/1/2",
                     frames_in_o, frames_drop_o, frames_out_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_eof_with_sof();
        test_watchdog();
        test_enable();
        test_proto();
`ifdef CONV_SCHED_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
